// File: rtl/ntm_lstm_matrix_feeder.sv
// Buffered row-major matrix source for the convolutional LSTM operand inputs.
// The host fills the buffer and pulses START; elements then stream out under acknowledge handshaking.
module ntm_lstm_matrix_feeder #(
  parameter int DATA_SIZE  = 64,
  parameter int SIZE_I_MAX = 8,
  parameter int SIZE_J_MAX = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic                 LOAD_ENABLE,
  input  logic [DATA_SIZE-1:0] LOAD_DATA,
  output logic                 OVERFLOW,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 DATA_OUT_I_ENABLE,
  output logic                 DATA_OUT_J_ENABLE,
  input  logic                 DATA_IN_J_ENABLE
);

  localparam int DEPTH = SIZE_I_MAX * SIZE_J_MAX;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int IW    = (SIZE_I_MAX > 1) ? $clog2(SIZE_I_MAX) : 1;
  localparam int JW    = (SIZE_J_MAX > 1) ? $clog2(SIZE_J_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [IW-1:0]          i_r, i_nxt_s, i_last_r, i_last_nxt_s, i_clamp_s;
  logic [JW-1:0]          j_r, j_nxt_s, j_last_r, j_last_nxt_s, j_clamp_s;
  logic [AW-1:0]          rd_addr_r, rd_addr_nxt_s;
  logic [PW-1:0]          wptr_r;
  logic                   overflow_r;
  logic                   zero_size_s;
  logic                   load_ok_s;
  logic                   wr_en_s;
  logic [DATA_SIZE-1:0]   data_out_r, data_nxt_s;
  logic                   i_en_r, i_en_nxt_s;
  logic                   j_en_r, j_en_nxt_s;
  logic                   ready_r, ready_nxt_s;
  logic [DATA_SIZE-1:0]   buf_mem [DEPTH];

  // Size clamping: sizes are held as last-index values so a size of 0 is flagged separately.
  always_comb begin
    zero_size_s = (SIZE_I_IN == {DATA_SIZE{1'b0}}) || (SIZE_J_IN == {DATA_SIZE{1'b0}});
    if (SIZE_I_IN > DATA_SIZE'(SIZE_I_MAX)) begin
      i_clamp_s = IW'(SIZE_I_MAX - 32'sd1);
    end else begin
      i_clamp_s = IW'(SIZE_I_IN - DATA_SIZE'(1'b1));
    end
    if (SIZE_J_IN > DATA_SIZE'(SIZE_J_MAX)) begin
      j_clamp_s = JW'(SIZE_J_MAX - 32'sd1);
    end else begin
      j_clamp_s = JW'(SIZE_J_IN - DATA_SIZE'(1'b1));
    end
  end

  // Load qualification: loads only in IDLE, START wins over a simultaneous load.
  always_comb begin
    load_ok_s = (state_r == IDLE) && LOAD_ENABLE && !START;
    wr_en_s   = load_ok_s && (wptr_r != PW'(DEPTH));
  end

  // State register and stream indices.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= IDLE;
      i_r       <= {IW{1'b0}};
      j_r       <= {JW{1'b0}};
      i_last_r  <= {IW{1'b0}};
      j_last_r  <= {JW{1'b0}};
      rd_addr_r <= {AW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      i_r       <= i_nxt_s;
      j_r       <= j_nxt_s;
      i_last_r  <= i_last_nxt_s;
      j_last_r  <= j_last_nxt_s;
      rd_addr_r <= rd_addr_nxt_s;
    end
  end

  // Next-state and index sequencing; the read address walks linearly since storage is row-major.
  always_comb begin
    state_nxt_s   = state_r;
    i_nxt_s       = i_r;
    j_nxt_s       = j_r;
    i_last_nxt_s  = i_last_r;
    j_last_nxt_s  = j_last_r;
    rd_addr_nxt_s = rd_addr_r;
    case (state_r)
      IDLE: begin
        if (START) begin
          i_nxt_s       = {IW{1'b0}};
          j_nxt_s       = {JW{1'b0}};
          i_last_nxt_s  = i_clamp_s;
          j_last_nxt_s  = j_clamp_s;
          rd_addr_nxt_s = {AW{1'b0}};
          if (zero_size_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = EMIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EMIT: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (DATA_IN_J_ENABLE) begin
          if (j_r < j_last_r) begin
            j_nxt_s       = j_r + JW'(1'b1);
            rd_addr_nxt_s = rd_addr_r + AW'(1'b1);
            state_nxt_s   = EMIT;
          end else if (i_r < i_last_r) begin
            i_nxt_s       = i_r + IW'(1'b1);
            j_nxt_s       = {JW{1'b0}};
            rd_addr_nxt_s = rd_addr_r + AW'(1'b1);
            state_nxt_s   = EMIT;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output comes straight from a flop.
  always_comb begin
    j_en_nxt_s  = (state_nxt_s == EMIT);
    i_en_nxt_s  = (state_nxt_s == EMIT) && (j_nxt_s == {JW{1'b0}});
    ready_nxt_s = (state_nxt_s == DONE);
    if (state_nxt_s == EMIT) begin
      data_nxt_s = buf_mem[rd_addr_nxt_s];
    end else begin
      data_nxt_s = data_out_r;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_out_r <= {DATA_SIZE{1'b0}};
      i_en_r     <= 1'b0;
      j_en_r     <= 1'b0;
      ready_r    <= 1'b0;
    end else begin
      data_out_r <= data_nxt_s;
      i_en_r     <= i_en_nxt_s;
      j_en_r     <= j_en_nxt_s;
      ready_r    <= ready_nxt_s;
    end
  end

  // Write pointer and sticky overflow; START rewinds the pointer so reloads start at address 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr_r     <= {PW{1'b0}};
      overflow_r <= 1'b0;
    end else if ((state_r == IDLE) && START) begin
      wptr_r <= {PW{1'b0}};
    end else if (wr_en_s) begin
      wptr_r <= wptr_r + PW'(1'b1);
    end else if (load_ok_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Buffer storage, intentionally not reset so contents survive a stream abort.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      buf_mem[wptr_r[AW-1:0]] <= LOAD_DATA;
    end
  end

  assign READY             = ready_r;
  assign OVERFLOW          = overflow_r;
  assign DATA_OUT          = data_out_r;
  assign DATA_OUT_I_ENABLE = i_en_r;
  assign DATA_OUT_J_ENABLE = j_en_r;

endmodule

// File: tb/tb_ntm_lstm_matrix_feeder.sv
// Directed bench for ntm_lstm_matrix_feeder: expected elements are queued when loaded
// and popped as the feeder strobes them out; strobe/READY timing is predicted from the handshake.
module tb_ntm_lstm_matrix_feeder;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        READY;
  logic [63:0] SIZE_I_IN;
  logic [63:0] SIZE_J_IN;
  logic        LOAD_ENABLE;
  logic [63:0] LOAD_DATA;
  logic        OVERFLOW;
  logic [63:0] DATA_OUT;
  logic        DATA_OUT_I_ENABLE;
  logic        DATA_OUT_J_ENABLE;
  logic        DATA_IN_J_ENABLE;

  int tests;
  int fails;
  logic [63:0] sb[$];

  ntm_lstm_matrix_feeder dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .READY(READY),
    .SIZE_I_IN(SIZE_I_IN),
    .SIZE_J_IN(SIZE_J_IN),
    .LOAD_ENABLE(LOAD_ENABLE),
    .LOAD_DATA(LOAD_DATA),
    .OVERFLOW(OVERFLOW),
    .DATA_OUT(DATA_OUT),
    .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE),
    .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
    .DATA_IN_J_ENABLE(DATA_IN_J_ENABLE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [63:0] v);
    LOAD_ENABLE = 1'b1;
    LOAD_DATA   = v;
    @(posedge CLK); #1;
    LOAD_ENABLE = 1'b0;
  endtask

  // Drives START with the given sizes, then acks each element k cycles after its strobe
  // (or holds the ack high) and checks strobes, data and READY cycle by cycle.
  task automatic run_stream(input logic [63:0] si, input logic [63:0] sj, input int n,
                            input int ncols, input int k, input bit hold,
                            input int start_at, input int abort_at);
    int elem;
    int next_exp;
    int last_emit;
    bit exp_jen;
    bit exp_ready;
    logic [63:0] last_data;
    logic [63:0] exp_d;
    elem = 0;
    next_exp = 1;
    last_emit = 0;
    last_data = 64'd0;
    SIZE_I_IN = si;
    SIZE_J_IN = sj;
    START = 1'b1;
    DATA_IN_J_ENABLE = hold;
    for (int cyc = 1; cyc <= n * (k + 2) + 8; cyc++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      LOAD_ENABLE = 1'b0;
      if (cyc == abort_at) begin
        RST = 1'b0;
        #1;
        chk("abort_data", DATA_OUT, 64'd0);
        chk("abort_jen", {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
        chk("abort_ien", {63'd0, DATA_OUT_I_ENABLE}, 64'd0);
        chk("abort_ready", {63'd0, READY}, 64'd0);
        DATA_IN_J_ENABLE = 1'b0;
        return;
      end
      exp_jen   = (elem < n) && (cyc == next_exp);
      exp_ready = (elem == n) && (cyc == next_exp);
      chk("j_enable", {63'd0, DATA_OUT_J_ENABLE}, {63'd0, exp_jen});
      chk("ready", {63'd0, READY}, {63'd0, exp_ready});
      if (DATA_OUT_J_ENABLE) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 64'd1, 64'd0);
        end else begin
          exp_d = sb.pop_front();
          chk("data", DATA_OUT, exp_d);
          last_data = exp_d;
        end
        chk("i_enable", {63'd0, DATA_OUT_I_ENABLE}, {63'd0, (elem % ncols) == 0});
      end else begin
        chk("i_enable_idle", {63'd0, DATA_OUT_I_ENABLE}, 64'd0);
        if (elem > 0 && !exp_ready) chk("data_hold", DATA_OUT, last_data);
      end
      if (exp_jen) begin
        elem++;
        last_emit = cyc;
        next_exp = cyc + (hold ? 1 : k) + 1;
      end
      DATA_IN_J_ENABLE = hold ? 1'b1 : (elem > 0 && cyc == last_emit + k);
      if (cyc == start_at) begin
        START = 1'b1;
        SIZE_I_IN = 64'd1;
        SIZE_J_IN = 64'd1;
        LOAD_ENABLE = 1'b1;
        LOAD_DATA = 64'hdead_beef;
      end
      if (exp_ready) break;
    end
    DATA_IN_J_ENABLE = 1'b0;
    @(posedge CLK); #1;
    chk("ready_pulse_end", {63'd0, READY}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST = 1'b0;
    START = 1'b0;
    SIZE_I_IN = 64'd0;
    SIZE_J_IN = 64'd0;
    LOAD_ENABLE = 1'b0;
    LOAD_DATA = 64'd0;
    DATA_IN_J_ENABLE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", {63'd0, READY}, 64'd0);
    chk("rst_data", DATA_OUT, 64'd0);
    chk("rst_ien", {63'd0, DATA_OUT_I_ENABLE}, 64'd0);
    chk("rst_jen", {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
    chk("rst_overflow", {63'd0, OVERFLOW}, 64'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // 2x2, ack one cycle after each strobe
    for (int w = 0; w < 4; w++) load_word(64'h10 + 64'(w));
    for (int w = 0; w < 4; w++) sb.push_back(64'h10 + 64'(w));
    run_stream(64'd2, 64'd2, 4, 2, 1, 1'b0, -1, -1);

    // same buffer re-streamed, ack delayed 3 cycles
    for (int w = 0; w < 4; w++) sb.push_back(64'h10 + 64'(w));
    run_stream(64'd2, 64'd2, 4, 2, 3, 1'b0, -1, -1);

    // ack held high continuously
    for (int w = 0; w < 4; w++) sb.push_back(64'h10 + 64'(w));
    run_stream(64'd2, 64'd2, 4, 2, 1, 1'b1, -1, -1);

    // zero-size column count
    run_stream(64'd2, 64'd0, 0, 1, 1, 1'b0, -1, -1);

    // START and a load pulsed during WAIT are both ignored
    for (int w = 0; w < 4; w++) sb.push_back(64'h10 + 64'(w));
    run_stream(64'd2, 64'd2, 4, 2, 1, 1'b0, 2, -1);
    chk("no_overflow", {63'd0, OVERFLOW}, 64'd0);

    // reset during the third WAIT, then replay from element 0
    for (int w = 0; w < 4; w++) sb.push_back(64'h10 + 64'(w));
    run_stream(64'd2, 64'd2, 4, 2, 1, 1'b0, -1, 6);
    sb.delete();
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_no_ready", {63'd0, READY}, 64'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    for (int w = 0; w < 4; w++) sb.push_back(64'h10 + 64'(w));
    run_stream(64'd2, 64'd2, 4, 2, 1, 1'b0, -1, -1);

    // 65 loads overflow the 64-entry buffer; oversize START clamps to 8x8
    for (int w = 0; w < 65; w++) begin
      load_word(64'h1000 + 64'(w));
      if (w == 63) chk("overflow_at_full", {63'd0, OVERFLOW}, 64'd0);
    end
    chk("overflow_set", {63'd0, OVERFLOW}, 64'd1);
    for (int w = 0; w < 64; w++) sb.push_back(64'h1000 + 64'(w));
    run_stream(64'd9, 64'd9, 64, 8, 1, 1'b0, -1, -1);
    chk("overflow_sticky", {63'd0, OVERFLOW}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
